// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver with a double-buffered display value.
// Scans NUM_DIGITS hex digits at CLK_DIV cycles per digit. A new value can be
// loaded at any time, but it only reaches the digits at a frame boundary.
// Optional feature macro: SEG7_BRIGHTNESS_EN adds a 4-bit anode duty control.
module seg7_scan_display #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_DIV    = 100000
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_mask,
    input  logic                      blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    output logic [6:0]                out7,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     en_out,
    output logic                      frame_start
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PrW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DIGITS - 1);
    localparam logic [PrW-1:0]  PrescMax = PrW'(CLK_DIV - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PrW-1:0]            presc_q, presc_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   disp_val_q, pend_val_q, src_val;
    logic [NUM_DIGITS-1:0]     disp_dp_q, pend_dp_q, src_dp;
    logic [NUM_DIGITS-1:0]     disp_mask_q, pend_mask_q, src_mask;
    logic                      pend_flag_q;
    logic [6:0]                out7_q, out7_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d, anode_sel;
    logic                      fs_q;
    logic                      tick, boundary, swap;
    logic [3:0]                nib;
    logic                      dp_sel, mask_sel, lz_sel, zero_above, dark;

    // Prescaler, digit index and frame-boundary detection.
    always_comb begin
        tick     = (presc_q == PrescMax);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        boundary = tick && (idx_d == '0);
        swap     = boundary && pend_flag_q;
        // On a swapping boundary digit 0 must already see the pending contents.
        src_val  = swap ? pend_val_q  : disp_val_q;
        src_dp   = swap ? pend_dp_q   : disp_dp_q;
        src_mask = swap ? pend_mask_q : disp_mask_q;
    end

    // Select the digit for the new index and decide whether it is dark.
    always_comb begin
        nib        = 4'h0;
        dp_sel     = 1'b0;
        mask_sel   = 1'b0;
        lz_sel     = 1'b0;
        anode_sel  = '1;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            // zero_above: this nibble and every more-significant one are zero
            zero_above = zero_above && (src_val[4*i +: 4] == 4'h0);
            if (IdxW'(i) == idx_d) begin
                nib          = src_val[4*i +: 4];
                dp_sel       = src_dp[i];
                mask_sel     = src_mask[i];
                lz_sel       = zero_above;
                anode_sel[i] = 1'b0;
            end
        end
        dark    = mask_sel || (blank_lz && (idx_d != '0) && lz_sel);
        out7_d  = dark ? 7'h7F : hex_to_seg(nib);
        dp_d    = dark ? 1'b1 : ~dp_sel;
        anode_d = dark ? '1 : anode_sel;
    end

    // Scan state and registered segment outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= LastIdx;
            out7_q  <= 7'h7F;
            dp_q    <= 1'b1;
            anode_q <= '1;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            fs_q    <= boundary;
            if (tick) begin
                out7_q  <= out7_d;
                dp_q    <= dp_d;
                anode_q <= anode_d;
            end
        end
    end

    // Pending and display buffers; a load on the boundary edge stays pending.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_mask_q <= '0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_mask_q <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            if (swap) begin
                disp_val_q  <= pend_val_q;
                disp_dp_q   <= pend_dp_q;
                disp_mask_q <= pend_mask_q;
            end
            if (load) begin
                pend_val_q  <= value;
                pend_dp_q   <= dp_in;
                pend_mask_q <= digit_mask;
                pend_flag_q <= 1'b1;
            end else if (swap) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

`ifdef SEG7_BRIGHTNESS_EN
    localparam int unsigned SubLen = (CLK_DIV / 16 > 1) ? CLK_DIV / 16 : 1;
    localparam int unsigned SubW   = (SubLen > 1) ? $clog2(SubLen) : 1;
    localparam logic [SubW-1:0] SubMax = SubW'(SubLen - 1);

    logic [SubW-1:0]       sub_q, sub_d;
    logic [3:0]            phase_q, phase_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    // Sub-phase counter within a digit slot; anode gated by brightness.
    always_comb begin
        sub_d   = sub_q + 1'b1;
        phase_d = phase_q;
        if (tick) begin
            sub_d   = '0;
            phase_d = 4'h0;
        end else if (sub_q == SubMax) begin
            sub_d   = '0;
            phase_d = phase_q + 4'h1;
        end
        en_d = (phase_d <= brightness) ? (tick ? anode_d : anode_q) : '1;
    end

    // Registered duty-gated anodes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sub_q   <= '0;
            phase_q <= 4'h0;
            en_q    <= '1;
        end else begin
            sub_q   <= sub_d;
            phase_q <= phase_d;
            en_q    <= en_d;
        end
    end

    assign en_out = en_q;
`else
    assign en_out = anode_q;
`endif

    assign out7        = out7_q;
    assign dp_out      = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with NUM_DIGITS=4.
module tb_seg7_scan_display;

`ifdef SEG7_BRIGHTNESS_EN
    localparam int unsigned Cdiv = 32;
`else
    localparam int unsigned Cdiv = 4;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  digit_mask;
    logic        blank_lz;
    logic [6:0]  out7;
    logic        dp_out;
    logic [3:0]  en_out;
    logic        frame_start;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  brightness;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    seg7_scan_display #(
        .NUM_DIGITS (4),
        .CLK_DIV    (Cdiv)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .value       (value),
        .load        (load),
        .dp_in       (dp_in),
        .digit_mask  (digit_mask),
        .blank_lz    (blank_lz),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .out7        (out7),
        .dp_out      (dp_out),
        .en_out      (en_out),
        .frame_start (frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic adv(input int unsigned n);
        repeat (n) @(negedge Clk);
    endtask

    // Present a load for exactly one rising edge; returns one cycle later.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] m);
        value      = v;
        dp_in      = dp;
        digit_mask = m;
        load       = 1'b1;
        @(negedge Clk);
        load       = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_start !== 1'b1 && n < int'(20 * Cdiv)) begin
            @(negedge Clk);
            n++;
        end
        check_eq("frame_wait", {31'd0, frame_start}, 32'd1);
    endtask

    // Called at cycle 0 of a frame; checks all four slots and returns at the
    // next frame's cycle 0. segs = {d3, d2, d1, d0}.
    task automatic check_frame(input logic [27:0] segs);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < int'(Cdiv); c++) begin
                if (d == 0 && c == 0) check_eq("fs_high", {31'd0, frame_start}, 32'd1);
                if (d == 0 && c == 1) check_eq("fs_low", {31'd0, frame_start}, 32'd0);
                if (c == 0 || c == int'(Cdiv) - 1) begin
                    check_eq("frame_en", {28'd0, en_out}, {28'd0, ~(4'b0001 << d)});
                    check_eq("frame_seg", {25'd0, out7}, {25'd0, segs[7*d +: 7]});
                    check_eq("frame_dp", {31'd0, dp_out}, 32'd1);
                end
                @(negedge Clk);
            end
        end
        check_eq("fs_period", {31'd0, frame_start}, 32'd1);
    endtask

    initial begin
        Reset      = 1'b1;
        value      = '0;
        load       = 1'b0;
        dp_in      = '0;
        digit_mask = '0;
        blank_lz   = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        adv(2);
        check_eq("rst_out7", {25'd0, out7}, 32'h7F);
        check_eq("rst_dp", {31'd0, dp_out}, 32'd1);
        check_eq("rst_en", {28'd0, en_out}, 32'hF);
        check_eq("rst_fs", {31'd0, frame_start}, 32'd0);

        // Basic scan of 12AF over two frames.
        Reset = 1'b0;
        do_load(16'h12AF, 4'b0000, 4'b0000);
        check_eq("dark_after_rst", {28'd0, en_out}, 32'hF);
        wait_frame();
        check_frame({7'h79, 7'h24, 7'h08, 7'h0E});
        check_frame({7'h79, 7'h24, 7'h08, 7'h0E});

        // Mid-frame load must not tear the frame being shown.
        do_load(16'h1111, 4'b0000, 4'b0000);
        adv(4 * Cdiv - 1);
        check_eq("mid_d0_old", {25'd0, out7}, 32'h79);
        adv(2 * Cdiv);
        do_load(16'h2222, 4'b0000, 4'b0000);
        adv(Cdiv - 1);
        check_eq("mid_d3_en", {28'd0, en_out}, 32'h7);
        check_eq("mid_d3_seg", {25'd0, out7}, 32'h79);
        adv(Cdiv);
        check_eq("mid_next_fs", {31'd0, frame_start}, 32'd1);
        check_eq("mid_next_d0", {25'd0, out7}, 32'h24);

        // Load on the boundary edge, then a second load: last one wins.
        adv(4 * Cdiv - 1);
        do_load(16'h3333, 4'b0000, 4'b0000);
        do_load(16'h4444, 4'b0000, 4'b0000);
        check_eq("bnd_cur_d0", {25'd0, out7}, 32'h24);
        adv(3 * Cdiv - 1);
        check_eq("bnd_cur_d3", {25'd0, out7}, 32'h24);
        adv(Cdiv);
        check_eq("bnd_next_d0", {25'd0, out7}, 32'h19);
        check_eq("bnd_next_en", {28'd0, en_out}, 32'hE);
        adv(3 * Cdiv);
        check_eq("bnd_next_d3", {25'd0, out7}, 32'h19);
        adv(Cdiv);

        // Leading-zero blanking and decimal point.
        blank_lz = 1'b1;
        do_load(16'h0050, 4'b0001, 4'b0000);
        adv(4 * Cdiv - 1);
        check_eq("lz_d0_seg", {25'd0, out7}, 32'h40);
        check_eq("lz_d0_dp", {31'd0, dp_out}, 32'd0);
        check_eq("lz_d0_en", {28'd0, en_out}, 32'hE);
        adv(Cdiv);
        check_eq("lz_d1_seg", {25'd0, out7}, 32'h12);
        check_eq("lz_d1_dp", {31'd0, dp_out}, 32'd1);
        check_eq("lz_d1_en", {28'd0, en_out}, 32'hD);
        adv(Cdiv);
        check_eq("lz_d2_en", {28'd0, en_out}, 32'hF);
        check_eq("lz_d2_seg", {25'd0, out7}, 32'h7F);
        adv(Cdiv);
        check_eq("lz_d3_en", {28'd0, en_out}, 32'hF);
        adv(Cdiv);

        // Digit mask darkens digit 1.
        do_load(16'h0050, 4'b0001, 4'b0010);
        adv(4 * Cdiv - 1);
        check_eq("mask_d0_seg", {25'd0, out7}, 32'h40);
        adv(Cdiv);
        check_eq("mask_d1_en", {28'd0, en_out}, 32'hF);
        check_eq("mask_d1_seg", {25'd0, out7}, 32'h7F);
        check_eq("mask_d1_dp", {31'd0, dp_out}, 32'd1);
        adv(3 * Cdiv);

        // Asynchronous reset mid-slot discards a pending load.
        blank_lz = 1'b0;
        do_load(16'h9999, 4'b1111, 4'b0000);
        adv(1);
        #2 Reset = 1'b1;
        #1;
        check_eq("arst_out7", {25'd0, out7}, 32'h7F);
        check_eq("arst_dp", {31'd0, dp_out}, 32'd1);
        check_eq("arst_en", {28'd0, en_out}, 32'hF);
        check_eq("arst_fs", {31'd0, frame_start}, 32'd0);
        adv(2);
        Reset = 1'b0;
        wait_frame();
        check_eq("post_rst_d0", {25'd0, out7}, 32'h40);
        check_eq("post_rst_en", {28'd0, en_out}, 32'hE);
        check_eq("post_rst_dp", {31'd0, dp_out}, 32'd1);
        adv(3 * Cdiv);
        check_eq("post_rst_d3", {25'd0, out7}, 32'h40);
        check_eq("post_rst_d3en", {28'd0, en_out}, 32'h7);
        adv(Cdiv);

`ifdef SEG7_BRIGHTNESS_EN
        // Brightness 3: anode low for 4 of 16 sub-phases.
        begin
            int low = 0;
            brightness = 4'd3;
            adv(4 * Cdiv);
            for (int c = 0; c < int'(Cdiv); c++) begin
                if (c == 7) check_eq("br_c7_en", {28'd0, en_out}, 32'hE);
                if (c == 8) check_eq("br_c8_en", {28'd0, en_out}, 32'hF);
                if (c == int'(Cdiv) - 1) check_eq("br_seg", {25'd0, out7}, 32'h40);
                if (en_out[0] == 1'b0) low++;
                @(negedge Clk);
            end
            check_eq("br_low_cycles", low, 32'd8);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment driver. It is the next generation of the fixed two-by-four-digit display used at the top level.
- Scans NUM_DIGITS hex digits at a programmable per-digit rate.
- Double-buffers the displayed value so a digit can never be updated mid-frame (no tearing). Supports per-digit decimal points, a digit mask and leading-zero blanking.
- Sits between the datapath result registers and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 2..16.
- CLK_DIV, 100000, Clk cycles each digit is displayed; must be ≥2 (≥16 and a multiple of 16 with SEG7_BRIGHTNESS_EN).

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous active-high reset
- value  input  4*NUM_DIGITS  hex nibbles; nibble i shown on digit i (digit 0 = rightmost)
- load  input  1  capture value/dp_in/digit_mask into the pending buffer this cycle
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_mask  input  NUM_DIGITS  1 = digit forced dark
- blank_lz  input  1  level; 1 = suppress leading zeros
- out7  output  7  segments, active low, out7[0]=a … out7[6]=g
- dp_out  output  1  decimal point, active low
- en_out  output  NUM_DIGITS  digit anodes, active low, at most one low
- frame_start  output  1  one-cycle pulse when digit 0 begins a frame

Behaviour:
- Reset values (asynchronous):
  - prescaler 0, digit index NUM_DIGITS-1
  - display and pending buffers 0, pending flag 0
  - out7 7'h7F, dp_out 1, en_out all ones, frame_start 0
- Prescaler counts 0..CLK_DIV-1. tick = (prescaler == CLK_DIV-1). On a tick the prescaler returns to 0.
- On each tick:
  - index ← (index == NUM_DIGITS-1) ? 0 : index+1
  - out7, dp_out and en_out are registered on that same edge from the NEW index.
  - Each digit is therefore driven for exactly CLK_DIV cycles. All outputs stay dark for the first CLK_DIV cycles after reset.
- Frame boundary = tick with new index 0:
  - frame_start is high for the following cycle.
  - If the pending flag is set, pending → display on that edge and the flag clears. The new contents are used for digit 0 of that same frame.
- load:
  - Copies the inputs to pending and sets the flag. The last load before a boundary wins.
  - A load on the boundary edge itself lands in pending, not display, and is shown next frame.
- Decode: standard hex, active low.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Leading-zero blanking (blank_lz=1): digit i is blank when every nibble at index ≥ i in the display buffer is 0. Digit 0 is never blanked, so value 0 shows "0".
- Blank or masked digit: en_out bit stays high (no anode driven), out7 = 7'h7F, dp_out = 1.
  - The dp of a blanked digit is also suppressed; the dp of a masked digit is suppressed.
- blank_lz is sampled live each tick; it is not buffered.
- Reset mid-frame: everything returns to reset values immediately and any pending load is discarded.

Optional Feature:
- Macro SEG7_BRIGHTNESS_EN.
- Defined:
  - Adds input brightness[3:0].
  - Each digit slot is split into 16 equal sub-phases of CLK_DIV/16 cycles.
  - The active digit's en_out bit is low only while sub-phase ≤ brightness (registered). brightness=15 gives full duty; brightness=0 gives 1/16 duty.
  - out7 and dp_out are unaffected.
  - brightness is sampled live.
- Not defined: no brightness port; the active digit is enabled for the whole slot.

Test Plan:
- Sim config for all scenarios: NUM_DIGITS=4, CLK_DIV=4.
- Reset, then value=16'h12AF loaded, then 2 frames. Required response:
  - en_out sequence 1110,1101,1011,0111, each held 4 cycles.
  - out7 sequence 7'h0E, 7'h08, 7'h24, 7'h79.
  - frame_start pulses every 16 cycles.
- Mid-frame consistency: display=16'h1111; load 16'h2222 while index=2. Required response:
  - Digit 3 still shows 7'h79.
  - Digit 0 of the next frame shows 7'h24.
- Boundary and last-wins: load 16'h3333 on the boundary edge, then 16'h4444 one cycle later. Required response:
  - The current frame shows the old value.
  - The next frame shows 4 (7'h19) on all digits.
- Blanking and masking: blank_lz=1, value=16'h0050, dp_in=4'b0001, digit_mask=4'b0000. Required response:
  - Digits 3 and 2 keep en_out high.
  - Digit 1 shows 7'h12.
  - Digit 0 shows 7'h40 with dp_out=0.
  - Then digit_mask=4'b0010 (loaded) makes digit 1 dark.
- Reset asserted asynchronously mid-slot with a pending load. Required response:
  - Outputs go to 7'h7F / 1 / 4'b1111 without waiting for a clock edge.
  - After release, the display shows 0s with blank_lz=0; the pending value is gone.
- SEG7_BRIGHTNESS_EN, CLK_DIV=32, brightness=3. Required response: the active en_out bit is low for 8 of every 32 cycles, then high for the remaining 24.
